// File: rtl/mdu_hilo.sv
// mdu_hilo: fixed-latency MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers.
// Result is computed at issue and committed after N busy cycles; MDU_FLUSH_EN adds a flush port.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        flush_w;
    logic [63:0] prod_s, prod_u;
    logic        div_sgn;
    logic [31:0] abs_a, abs_b, div_b, uq, ur, quo, rem;

`ifdef MDU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign div_sgn = (op == 3'd2);
    assign abs_a   = (div_sgn && A[31]) ? -A : A;
    assign abs_b   = (div_sgn && B[31]) ? -B : B;
    assign div_b   = (B == 32'd0) ? 32'd1 : abs_b;
    assign uq      = abs_a / div_b;
    assign ur      = abs_a % div_b;
    assign quo     = (div_sgn && (A[31] ^ B[31])) ? -uq : uq;
    assign rem     = (div_sgn && A[31]) ? -ur : ur;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        skip_d  = skip_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && !flush_w) begin
                    case (op)
                        3'd0, 3'd1: begin
                            pend_d  = (op == 3'd0) ? prod_s : prod_u;
                            skip_d  = 1'b0;
                            cnt_d   = MULT_LD;
                            state_d = RUN;
                        end
                        3'd2, 3'd3: begin
                            pend_d  = {rem, quo};
                            skip_d  = (B == 32'd0);
                            cnt_d   = DIV_LD;
                            state_d = RUN;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush_w) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    pend_d  = 64'd0;
                    skip_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    // Divide-by-zero leaves HI/LO untouched but still spends the full latency.
                    if (!skip_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    state_d = IDLE;
                    pend_d  = 64'd0;
                    skip_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            skip_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            skip_q  <= skip_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
